// File: rtl/sdram_cmd_pkg.sv
// Shared types for the SDRAM command responder: command word layout and
// the service FSM state encoding.
package sdram_cmd_pkg;

    localparam int CMD_W  = 41;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EXEC = 2'd2
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers; an extra pointer MSB tells
// full from empty, so all status flags follow the registered occupancy.
module sync_fifo #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int ALM_LVL = 1
) (
    input  logic                     clk,
    input  logic                     reset_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     alm_full_o,
    output logic                     alm_empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ALM_FULL_CNT  = (AW+1)'(DEPTH - ALM_LVL);
    localparam logic [AW:0] ALM_EMPTY_CNT = (AW+1)'(ALM_LVL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign count_o     = wr_ptr_q - rd_ptr_q;
    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign alm_full_o  = (count_o >= ALM_FULL_CNT);
    assign alm_empty_o = (count_o <= ALM_EMPTY_CNT);
    assign dout_o      = mem_q[rd_ptr_q[AW-1:0]];

    // Requests against the registered flags: a same-cycle pop never opens
    // room for a push into a full FIFO.
    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n_i && do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/sdram_cmd_responder.sv
// SDRAM controller stand-in: queues host commands, executes them one at a
// time against an internal RAM after a fixed latency, returns read data.
module sdram_cmd_responder
    import sdram_cmd_pkg::*;
#(
    parameter int CMD_DEPTH = 8,
    parameter int RD_DEPTH  = 8,
    parameter int MEM_AW    = 10,
    parameter int LATENCY   = 4
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic [CMD_W-1:0]  writer_d_i,
    input  logic              writer_enq_i,
    output logic              writer_full_o,
    output logic              writer_alm_full_o,
    output logic [DATA_W-1:0] reader_q_o,
    input  logic              reader_deq_i,
    output logic              reader_empty_o,
    output logic              reader_alm_empty_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    cmd_t              cmd_q, cmd_d;
    cmd_t              cmd_head;
    logic              cmd_full, cmd_empty, cmd_alm_full, cmd_alm_empty;
    logic [$clog2(CMD_DEPTH):0] cmd_cnt;
    logic [DATA_W-1:0] rd_head;
    logic              rd_full, rd_empty, rd_alm_full, rd_alm_empty;
    logic [$clog2(RD_DEPTH):0]  rd_cnt;
    logic              cmd_pop, mem_we, rd_push;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_q [2**MEM_AW];
    logic [DATA_W-1:0] reader_q_q;
    logic              overflow_q, underflow_q;
    logic              unused_status;

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH), .ALM_LVL(1)) u_cmd_fifo (
        .clk         (clk),
        .reset_n_i   (reset_n_i),
        .push_i      (writer_enq_i),
        .din_i       (writer_d_i),
        .pop_i       (cmd_pop),
        .dout_o      (cmd_head),
        .full_o      (cmd_full),
        .empty_o     (cmd_empty),
        .alm_full_o  (cmd_alm_full),
        .alm_empty_o (cmd_alm_empty),
        .count_o     (cmd_cnt)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RD_DEPTH), .ALM_LVL(1)) u_rd_fifo (
        .clk         (clk),
        .reset_n_i   (reset_n_i),
        .push_i      (rd_push),
        .din_i       (mem_q[mem_addr]),
        .pop_i       (reader_deq_i),
        .dout_o      (rd_head),
        .full_o      (rd_full),
        .empty_o     (rd_empty),
        .alm_full_o  (rd_alm_full),
        .alm_empty_o (rd_alm_empty),
        .count_o     (rd_cnt)
    );

    // Status the block does not need; upper address bits alias away.
    assign unused_status = ^{cmd_alm_empty, cmd_cnt, rd_alm_full, rd_cnt, cmd_q.addr};
    assign mem_addr      = cmd_q.addr[MEM_AW-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        case (state_q)
            IDLE: begin
                if (!cmd_empty) begin
                    cmd_d   = cmd_head;
                    cnt_d   = LAT_M1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = EXEC;
                else             cnt_d   = cnt_q - 1'b1;
            end
            EXEC: begin
                // A read holds here until the read-data FIFO has room.
                if (cmd_q.we || !rd_full) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_pop = (state_q == IDLE) && !cmd_empty;
        mem_we  = (state_q == EXEC) && cmd_q.we;
        rd_push = (state_q == EXEC) && !cmd_q.we && !rd_full;
    end

    always_ff @(posedge clk) begin
        if (reset_n_i && mem_we) begin
            mem_q[mem_addr] <= cmd_q.data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            reader_q_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (reader_deq_i && !rd_empty) reader_q_q <= rd_head;
            if (writer_enq_i && cmd_full)  overflow_q  <= 1'b1;
            if (reader_deq_i && rd_empty)  underflow_q <= 1'b1;
        end
    end

    assign writer_full_o      = cmd_full;
    assign writer_alm_full_o  = cmd_alm_full;
    assign reader_q_o         = reader_q_q;
    assign reader_empty_o     = rd_empty;
    assign reader_alm_empty_o = rd_alm_empty;
    assign overflow_o         = overflow_q;
    assign underflow_o        = underflow_q;

endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Randomized bench for sdram_cmd_responder against a queue-based
// transaction model, plus directed scenarios with literal expectations.
module tb_sdram_cmd_responder;
    import sdram_cmd_pkg::*;

    localparam int CMD_DEPTH = 8;
    localparam int RD_DEPTH  = 8;
    localparam int MEM_AW    = 10;
    localparam int LAT       = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [40:0] wd = '0;
    logic        enq = 1'b0, deq = 1'b0;
    logic        w_full, w_alm_full, r_empty, r_alm_empty, ovf, unf;
    logic [15:0] r_q;

    always #5 clk = ~clk;

    sdram_cmd_responder #(
        .CMD_DEPTH(CMD_DEPTH), .RD_DEPTH(RD_DEPTH), .MEM_AW(MEM_AW), .LATENCY(LAT)
    ) dut (
        .clk                (clk),
        .reset_n_i          (reset_n),
        .writer_d_i         (wd),
        .writer_enq_i       (enq),
        .writer_full_o      (w_full),
        .writer_alm_full_o  (w_alm_full),
        .reader_q_o         (r_q),
        .reader_deq_i       (deq),
        .reader_empty_o     (r_empty),
        .reader_alm_empty_o (r_alm_empty),
        .overflow_o         (ovf),
        .underflow_o        (unf)
    );

    // Transaction model: queues for both FIFOs, one command in service with
    // a countdown of waiting cycles before it may execute.
    cmd_t        mq[$];
    logic [15:0] mr[$];
    logic [15:0] mmem [int];
    bit          busy = 0;
    int          left = 0;
    cmd_t        cur = '0;
    logic [15:0] m_q = '0;
    bit          m_ovf = 0, m_unf = 0;

    int n_vec = 0, n_bad = 0;
    bit chk_en = 0;
    logic [15:0] pool_val [8];

    always @(posedge clk) begin : model
        bit full_pre, rfull_pre;
        int idx;
        if (!reset_n) begin
            mq.delete(); mr.delete();
            busy = 0; left = 0; m_q = '0; m_ovf = 0; m_unf = 0;
        end else begin
            full_pre  = (mq.size() == CMD_DEPTH);
            rfull_pre = (mr.size() == RD_DEPTH);
            if (deq) begin
                if (mr.size() > 0) m_q = mr.pop_front();
                else               m_unf = 1;
            end
            if (!busy) begin
                if (mq.size() > 0) begin
                    cur = mq.pop_front(); busy = 1; left = LAT;
                end
            end else if (left > 0) begin
                left--;
            end else begin
                idx = int'(cur.addr[MEM_AW-1:0]);
                if (cur.we) begin
                    mmem[idx] = cur.data; busy = 0;
                end else if (!rfull_pre) begin
                    mr.push_back(mmem.exists(idx) ? mmem[idx] : 16'hxxxx); busy = 0;
                end
            end
            if (enq) begin
                if (!full_pre) mq.push_back(cmd_t'(wd));
                else           m_ovf = 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] b16(input logic b);
        return {15'd0, b};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("writer_full_o",      b16(w_full),      b16(mq.size() == CMD_DEPTH));
            chk("writer_alm_full_o",  b16(w_alm_full),  b16(mq.size() >= CMD_DEPTH - 1));
            chk("reader_empty_o",     b16(r_empty),     b16(mr.size() == 0));
            chk("reader_alm_empty_o", b16(r_alm_empty), b16(mr.size() <= 1));
            chk("reader_q_o",         r_q,              m_q);
            chk("overflow_o",         b16(ovf),         b16(m_ovf));
            chk("underflow_o",        b16(unf),         b16(m_unf));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic we, input logic [23:0] a, input logic [15:0] d);
        wd = {we, a, d}; enq = 1'b1; step(); enq = 1'b0;
    endtask

    task automatic push_wait(input logic we, input logic [23:0] a, input logic [15:0] d);
        int n = 0;
        while (w_full && n < 200) begin step(); n++; end
        if (w_full) begin
            n_vec++; n_bad++;
            $display("FAIL push_wait: command FIFO still full after %0d cycles", n);
        end
        push(we, a, d);
    endtask

    task automatic pop();
        deq = 1'b1; step(); deq = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; step(); reset_n = 1'b1; step();
    endtask

    task automatic idle_wait(input int maxc);
        int n = 0;
        while ((mq.size() != 0 || busy) && n < maxc) begin step(); n++; end
        if (mq.size() != 0 || busy) begin
            n_vec++; n_bad++;
            $display("FAIL drain: block still busy after %0d cycles, expected idle", n);
        end
    endtask

    task automatic wait_data(input int maxc);
        int n = 0;
        while (r_empty && n < maxc) begin step(); n++; end
        if (r_empty) begin
            n_vec++; n_bad++;
            $display("FAIL wait_data: read FIFO still empty after %0d cycles, expected data", n);
        end
    endtask

    function automatic logic [23:0] pool_addr(input int i);
        return {14'($urandom), 7'd0, 3'(i)};
    endfunction

    initial begin
        int n;
        reset_n = 1'b0;
        step();
        chk_en = 1;
        step();
        chk("rst reader_q_o", r_q, 16'h0000);
        chk("rst reader_empty_o", b16(r_empty), 16'h0001);
        chk("rst writer_full_o", b16(w_full), 16'h0000);
        reset_n = 1'b1;
        step();

        // Underflow is sticky and only reset clears it.
        pop();
        chk("underflow reader_q_o", r_q, 16'h0000);
        chk("underflow set", b16(unf), 16'h0001);
        do_reset();
        chk("underflow cleared", b16(unf), 16'h0000);

        // Write then single read into an idle block: exact enq-to-data time.
        push(1'b1, 24'h001000, 16'h1000);
        idle_wait(200);
        wd = {1'b0, 24'h001000, 16'h0000}; enq = 1'b1; step(); enq = 1'b0;
        n = 1;
        while (r_empty && n < 100) begin step(); n++; end
        chk("enq_to_data cycles", 16'(n), 16'(LAT + 3));
        pop();
        chk("read-after-write", r_q, 16'h1000);
        chk("no overflow", b16(ovf), 16'h0000);
        chk("no underflow", b16(unf), 16'h0000);

        // In-order completion across two addresses.
        push(1'b1, 24'h000010, 16'h1000);
        push(1'b1, 24'h000020, 16'h2000);
        push(1'b0, 24'h000020, 16'h0000);
        push(1'b0, 24'h000010, 16'h0000);
        idle_wait(400);
        pop();
        chk("order first", r_q, 16'h2000);
        pop();
        chk("order second", r_q, 16'h1000);

        // Fill the command FIFO while the first command waits out LAT.
        do_reset();
        for (int i = 0; i < CMD_DEPTH + 2; i++) begin
            push(1'b1, pool_addr(i % 8), 16'($urandom));
            if (i == 7) begin
                chk("alm_full at 7", b16(w_alm_full), 16'h0001);
                chk("not full at 7", b16(w_full), 16'h0000);
            end
            if (i == 8) begin
                chk("full at 8", b16(w_full), 16'h0001);
                chk("no overflow yet", b16(ovf), 16'h0000);
            end
        end
        chk("overflow set", b16(ovf), 16'h0001);
        idle_wait(600);
        chk("overflow sticky", b16(ovf), 16'h0001);
        do_reset();

        // Read back-pressure: more reads than the read FIFO holds.
        for (int i = 0; i < 8; i++) begin
            pool_val[i] = 16'($urandom);
            push_wait(1'b1, pool_addr(i), pool_val[i]);
        end
        idle_wait(400);
        for (int i = 0; i < RD_DEPTH + 2; i++) push_wait(1'b0, pool_addr(i % 8), 16'h0000);
        n = 0;
        while (!(mr.size() == RD_DEPTH && busy && left == 0) && n < 600) begin step(); n++; end
        repeat (10) step();
        chk("backpressure alm_empty", b16(r_alm_empty), 16'h0000);
        chk("backpressure rd full", 16'(mr.size()), 16'(RD_DEPTH));
        for (int i = 0; i < RD_DEPTH + 2; i++) begin
            wait_data(100);
            pop();
            chk("backpressure data", r_q, pool_val[i % 8]);
        end
        idle_wait(200);
        chk("drained empty", b16(r_empty), 16'h0001);

        // Reset during WAIT discards the pending write.
        push(1'b1, 24'h000005, 16'h1111);
        idle_wait(200);
        push(1'b1, 24'h000005, 16'hBEEF);
        repeat (3) step();
        do_reset();
        push(1'b0, 24'h000005, 16'h0000);
        wait_data(100);
        pop();
        chk("reset drops write", r_q, 16'h1111);

        // Address aliasing onto MEM_AW bits.
        push(1'b1, 24'h000405, 16'h5A5A);
        push(1'b0, 24'h000005, 16'h0000);
        wait_data(200);
        pop();
        chk("alias read", r_q, 16'h5A5A);

        // Random traffic over the initialised address pool.
        for (int c = 0; c < 3000; c++) begin
            enq = ($urandom_range(0, 2) == 0);
            wd  = {1'($urandom), pool_addr($urandom_range(0, 7)), 16'($urandom)};
            deq = ($urandom_range(0, 2) == 0);
            reset_n = ($urandom_range(0, 599) != 0);
            step();
        end
        enq = 1'b0; deq = 1'b0; reset_n = 1'b1;
        idle_wait(1000);
        n = 0;
        while (!r_empty && n < 20) begin pop(); n++; end
        step();
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
